// File: rtl/dq_read_cal.sv
// Read-timing calibration for one DQ byte lane: sweeps the shared IDELAY tap,
// finds the first contiguous passing window and reloads the tap to its centre.
module dq_read_cal #(
  parameter int WIDTH   = 8,
  parameter int SETTLE  = 4,
  parameter int SAMPLES = 16
) (
  input  logic             i_mclk90,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_read_valid,
  input  logic [WIDTH-1:0] i_iserdes_q1,
  input  logic [WIDTH-1:0] i_iserdes_q2,
  output logic             o_read_req,
  output logic             o_dly_inc,
  output logic             o_dly_reset,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_fail,
  output logic [5:0]       o_tap_out,
  output logic [5:0]       o_win_left,
  output logic [5:0]       o_win_right
);

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_DRST   | reset IDELAY tap to 0, clear window tracker
  // S_SETTLE | wait for the delay line to settle
  // S_SAMPLE | request training reads, judge current tap
  // S_STEP   | increment tap
  // S_CRST   | reset tap before loading window centre
  // S_CINC   | step tap up to the centre
  // S_DONE   | calibration succeeded
  // S_FAIL   | no passing tap found
  typedef enum logic [3:0] {
    S_IDLE, S_DRST, S_SETTLE, S_SAMPLE, S_STEP, S_CRST, S_CINC, S_DONE, S_FAIL
  } state_t;

  localparam int SW  = $clog2(SETTLE + 1);
  localparam int SMW = $clog2(SAMPLES + 1);

  state_t         r_state, w_next;
  logic [5:0]     r_tap, w_tap;
  logic [SW-1:0]  r_settle, w_settle;
  logic [SMW-1:0] r_smp, w_smp;
  logic           r_pass, w_pass;
  logic           r_seen, w_seen;
  logic           r_closed, w_closed;
  logic [5:0]     r_inc, w_inc;
  logic [5:0]     r_tap_out, w_tap_out;
  logic [5:0]     r_win_left, w_win_left;
  logic [5:0]     r_win_right, w_win_right;
  logic           r_read_req, r_dly_inc, r_dly_reset, r_busy, r_done, r_fail;
  logic           w_match, w_pass_final;
  logic [6:0]     w_centre_sum;
  logic [5:0]     w_centre;

  assign w_match      = (i_iserdes_q1 == '1) && (i_iserdes_q2 == '0);
  assign w_pass_final = r_pass & w_match;
  assign w_centre_sum = {1'b0, r_win_left} + {1'b0, r_win_right};
  assign w_centre     = 6'(w_centre_sum >> 1);

  always_comb begin
    w_next      = r_state;
    w_tap       = r_tap;
    w_settle    = r_settle;
    w_smp       = r_smp;
    w_pass      = r_pass;
    w_seen      = r_seen;
    w_closed    = r_closed;
    w_inc       = r_inc;
    w_tap_out   = r_tap_out;
    w_win_left  = r_win_left;
    w_win_right = r_win_right;
    case (r_state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (i_start) begin
          w_next      = S_DRST;
          w_tap_out   = '0;
          w_win_left  = '0;
          w_win_right = '0;
        end
      end
      S_DRST: begin
        w_tap    = '0;
        w_seen   = 1'b0;
        w_closed = 1'b0;
        w_settle = SW'(SETTLE - 1);
        w_next   = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_settle == '0) begin
          w_smp  = '0;
          w_pass = 1'b1;
          w_next = S_SAMPLE;
        end else begin
          w_settle = r_settle - 1'b1;
        end
      end
      S_SAMPLE: begin
        if (i_read_valid) begin
          w_smp = r_smp + 1'b1;
          if (!w_match) w_pass = 1'b0;
          if (r_smp == SMW'(SAMPLES - 1)) begin
            if (w_pass_final) begin
              w_win_right = r_tap;
              if (!r_seen) begin
                w_win_left = r_tap;
                w_seen     = 1'b1;
              end
            end else if (r_seen) begin
              w_closed = 1'b1;
            end
            // w_seen/w_closed already hold this tap's verdict here
            if (w_closed || r_tap == 6'd63) w_next = w_seen ? S_CRST : S_FAIL;
            else                            w_next = S_STEP;
          end
        end
      end
      S_STEP: begin
        w_tap    = r_tap + 1'b1;
        w_settle = SW'(SETTLE - 1);
        w_next   = S_SETTLE;
      end
      S_CRST: begin
        w_inc = w_centre;
        if (w_centre == '0) begin
          w_tap_out = w_centre;
          w_next    = S_DONE;
        end else begin
          w_next = S_CINC;
        end
      end
      S_CINC: begin
        w_inc = r_inc - 1'b1;
        if (r_inc == 6'd1) begin
          w_tap_out = w_centre;
          w_next    = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_next == S_FAIL) w_tap_out = '0;
  end

  // every output is registered from the next-state decode so it lines up with the state
  always_ff @(posedge i_mclk90) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_tap       <= '0;
      r_settle    <= '0;
      r_smp       <= '0;
      r_pass      <= 1'b0;
      r_seen      <= 1'b0;
      r_closed    <= 1'b0;
      r_inc       <= '0;
      r_tap_out   <= '0;
      r_win_left  <= '0;
      r_win_right <= '0;
      r_read_req  <= 1'b0;
      r_dly_inc   <= 1'b0;
      r_dly_reset <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_tap       <= w_tap;
      r_settle    <= w_settle;
      r_smp       <= w_smp;
      r_pass      <= w_pass;
      r_seen      <= w_seen;
      r_closed    <= w_closed;
      r_inc       <= w_inc;
      r_tap_out   <= w_tap_out;
      r_win_left  <= w_win_left;
      r_win_right <= w_win_right;
      r_read_req  <= (w_next == S_SAMPLE);
      r_dly_inc   <= (w_next == S_STEP) || (w_next == S_CINC);
      r_dly_reset <= (w_next == S_DRST) || (w_next == S_CRST);
      r_busy      <= !((w_next == S_IDLE) || (w_next == S_DONE) || (w_next == S_FAIL));
      r_done      <= (w_next == S_DONE);
      r_fail      <= (w_next == S_FAIL);
    end
  end

  assign o_read_req  = r_read_req;
  assign o_dly_inc   = r_dly_inc;
  assign o_dly_reset = r_dly_reset;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_fail      = r_fail;
  assign o_tap_out   = r_tap_out;
  assign o_win_left  = r_win_left;
  assign o_win_right = r_win_right;

endmodule
